ama_riscv_pipe_ctrl: RTL
========================

AMA_RISCV_PIPE_CTRL -- requirements
Module: ama_riscv_pipe_ctrl

Interface
REQ-001 Parameter NUM_FWD, default 2, meaning count of in-flight writeback stages eligible for forwarding (legal 1..4); index 0 = youngest (EX).
REQ-002 Parameter DMEM_TIMEOUT, default 15, meaning max consecutive data-memory wait cycles before abort (legal 1..255).
REQ-003 Localparam FWD_W = $clog2(NUM_FWD+1), meaning forwarding-select width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset (asserted at 0).
REQ-006 rs1_id, rs2_id  in  5 each  ID-stage source register indices.
REQ-007 rs1_used_id, rs2_used_id  in  1 each  ID instruction actually reads that source.
REQ-008 rd_vec  in  NUM_FWD x 5  destination index per forwarding stage.
REQ-009 reg_we_vec  in  NUM_FWD  register write enable per forwarding stage.
REQ-010 load_inst_ex  in  1  EX instruction is a load.
REQ-011 mispredict_ex  in  1  EX branch/jump resolved against fetch path.
REQ-012 dmem_req  in  1  MEM stage issues a data-memory access this cycle.
REQ-013 dmem_ack  in  1  data memory completes the outstanding access.
REQ-014 stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold corresponding pipeline register.
REQ-015 clear_id, clear_ex  out  1 each  insert bubble into that stage register.
REQ-016 pc_we  out  1  PC update enable.
REQ-017 fwd_a_sel, fwd_b_sel  out  FWD_W each  0 = register file, k = stage k-1.
REQ-018 timeout_err  out  1  sticky data-memory timeout flag.

Function
REQ-019 FSM states RUN, MEM_WAIT, LD_BUBBLE; reset state RUN.
REQ-020 RUN priority (highest first): memory wait, mispredict, load-use, normal.
REQ-021 Memory wait: dmem_req=1 and dmem_ack=0 in RUN -> stall_if/id/ex/mem=1, pc_we=0 that cycle, next state MEM_WAIT, wait counter loaded with 1.
REQ-022 MEM_WAIT: all four stalls=1, pc_we=0, counter increments each cycle; dmem_ack=1 -> stalls released same cycle, next state RUN, counter cleared.
REQ-023 MEM_WAIT: counter reaching DMEM_TIMEOUT without ack -> timeout_err set, stalls released same cycle, next state RUN; timeout_err stays 1 until reset.
REQ-024 mispredict_ex ignored in MEM_WAIT (EX frozen; re-presented after release).
REQ-025 Mispredict in RUN (no memory wait) -> clear_id=1, clear_ex=1, pc_we=1 same cycle; no stall; next state RUN.
REQ-026 Load-use hazard = load_inst_ex & reg_we_vec[0] & rd_vec[0]!=0 & ((rs1_used_id & rs1_id==rd_vec[0]) | (rs2_used_id & rs2_id==rd_vec[0])).
REQ-027 Load-use in RUN (no higher-priority event) -> stall_if=1, stall_id=1, clear_ex=1, pc_we=0 for exactly one cycle; next state LD_BUBBLE.
REQ-028 LD_BUBBLE: no load-use re-detection; outputs as RUN normal except memory-wait/mispredict still honoured with RUN priority; next state RUN or MEM_WAIT.
REQ-029 Normal RUN: all stalls/clears 0, pc_we=1.
REQ-030 Forwarding: fwd_x_sel = k+1 for smallest k with reg_we_vec[k]=1, rd_vec[k]==rs_x, rd_vec[k]!=0; else 0; combinational, independent of FSM.
REQ-031 Forwarding select with rs_x_used_id=0 SHALL be 0.
REQ-032 dmem_req and dmem_ack both 1 in same RUN cycle -> zero-wait access, no stall.

Reset
REQ-033 While rst=0: state RUN, counter 0, timeout_err 0, all stall/clear outputs 0, pc_we 0; forwarding selects remain combinational.
REQ-034 Reset asserted mid MEM_WAIT aborts wait immediately without setting timeout_err.

Structure
REQ-035 State enum and FWD_W computation SHALL live in shared package ama_riscv_pkg.
REQ-036 Per-operand priority match SHALL be sub-module ama_riscv_fwd_match (parametrised NUM_FWD), instantiated twice.

Verification
REQ-037 NUM_FWD=3: rs1_id=5, rd_vec={5,5,5}, reg_we_vec=3'b110 -> fwd_a_sel=2; rd_vec[0]=0 with we -> never selected.
REQ-038 load_inst_ex=1, rd_vec[0]=7, rs2_id=7, rs2_used_id=1 -> one cycle stall_if/stall_id/clear_ex, pc_we=0, then state RUN with identical inputs -> no stall.
REQ-039 dmem_req=1, ack after 4 cycles -> all stalls high 4 cycles, released in ack cycle, timeout_err=0.
REQ-040 DMEM_TIMEOUT=3, dmem_req=1, ack never -> stalls 3 cycles, timeout_err=1 and held, state RUN.
REQ-041 mispredict_ex and load-use same cycle -> clear_id=clear_ex=1, pc_we=1, no stall; mispredict during MEM_WAIT -> no clear.
REQ-042 rst driven 0 during MEM_WAIT -> all outputs reset values asynchronously, timeout_err=0.

Source files
------------

// File: rtl/ama_riscv_pkg.sv
// Shared types and helpers for the pipeline controller: FSM state encoding
// and the forwarding-select width calculation.
package ama_riscv_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MEM_WAIT  = 2'd1,
    ST_LD_BUBBLE = 2'd2
  } pipe_state_e;

  localparam int WAIT_CNT_W = 8;

  // Select value 0 means register file, 1..num_fwd picks a writeback stage.
  function automatic int fwd_w(input int num_fwd);
    return $clog2(num_fwd + 1);
  endfunction

endpackage

// File: rtl/ama_riscv_fwd_match.sv
// Per-operand forwarding select: the youngest writing stage whose destination
// matches the source register wins; x0 is never forwarded.
module ama_riscv_fwd_match
  import ama_riscv_pkg::*;
#(
  parameter  int NUM_FWD = 2,
  localparam int FWD_W   = fwd_w(NUM_FWD)
) (
  input  logic [4:0]              rs,
  input  logic                    rs_used,
  input  logic [NUM_FWD-1:0][4:0] rd_vec,
  input  logic [NUM_FWD-1:0]      reg_we_vec,
  output logic [FWD_W-1:0]        sel
);

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    sel = '0;
    if (rs_used) begin
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (reg_we_vec[k] && (rd_vec[k] == rs) && (rd_vec[k] != 5'd0)) begin
          sel = FWD_W'(k + 1);
        end
      end
    end
  end

endmodule

// File: rtl/ama_riscv_pipe_ctrl.sv
// Pipeline hazard controller: memory-wait stall with timeout, mispredict
// flush, load-use bubble, and operand forwarding selects.
module ama_riscv_pipe_ctrl
  import ama_riscv_pkg::*;
#(
  parameter  int NUM_FWD      = 2,
  parameter  int DMEM_TIMEOUT = 15,
  localparam int FWD_W        = fwd_w(NUM_FWD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              rs1_id,
  input  logic [4:0]              rs2_id,
  input  logic                    rs1_used_id,
  input  logic                    rs2_used_id,
  input  logic [NUM_FWD-1:0][4:0] rd_vec,
  input  logic [NUM_FWD-1:0]      reg_we_vec,
  input  logic                    load_inst_ex,
  input  logic                    mispredict_ex,
  input  logic                    dmem_req,
  input  logic                    dmem_ack,
  output logic                    stall_if,
  output logic                    stall_id,
  output logic                    stall_ex,
  output logic                    stall_mem,
  output logic                    clear_id,
  output logic                    clear_ex,
  output logic                    pc_we,
  output logic [FWD_W-1:0]        fwd_a_sel,
  output logic [FWD_W-1:0]        fwd_b_sel,
  output logic                    timeout_err
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(DMEM_TIMEOUT);

  pipe_state_e           state, state_nxt;
  logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic                  set_timeout;
  logic                  load_use;

  ama_riscv_fwd_match #(.NUM_FWD(NUM_FWD)) u_fwd_a (
    .rs         (rs1_id),
    .rs_used    (rs1_used_id),
    .rd_vec     (rd_vec),
    .reg_we_vec (reg_we_vec),
    .sel        (fwd_a_sel)
  );

  ama_riscv_fwd_match #(.NUM_FWD(NUM_FWD)) u_fwd_b (
    .rs         (rs2_id),
    .rs_used    (rs2_used_id),
    .rd_vec     (rd_vec),
    .reg_we_vec (reg_we_vec),
    .sel        (fwd_b_sel)
  );

  assign load_use = load_inst_ex && reg_we_vec[0] && (rd_vec[0] != 5'd0) &&
                    ((rs1_used_id && (rs1_id == rd_vec[0])) ||
                     (rs2_used_id && (rs2_id == rd_vec[0])));

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    set_timeout  = 1'b0;
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    stall_ex     = 1'b0;
    stall_mem    = 1'b0;
    clear_id     = 1'b0;
    clear_ex     = 1'b0;
    pc_we        = 1'b1;

    case (state)
      ST_RUN, ST_LD_BUBBLE: begin
        if (dmem_req && !dmem_ack) begin
          {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
          pc_we        = 1'b0;
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = WAIT_CNT_W'(1);
        end else if (mispredict_ex) begin
          clear_id  = 1'b1;
          clear_ex  = 1'b1;
          state_nxt = ST_RUN;
        end else if (load_use && (state == ST_RUN)) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          clear_ex  = 1'b1;
          pc_we     = 1'b0;
          state_nxt = ST_LD_BUBBLE;
        end else begin
          state_nxt = ST_RUN;
        end
      end

      // EX is frozen here, so a mispredict is simply re-presented on release.
      ST_MEM_WAIT: begin
        if (dmem_ack) begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt >= TIMEOUT_CNT) begin
          set_timeout  = 1'b1;
          state_nxt    = ST_RUN;
          wait_cnt_nxt = '0;
        end else begin
          {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
          pc_we        = 1'b0;
          wait_cnt_nxt = wait_cnt + WAIT_CNT_W'(1);
        end
      end

      default: begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = '0;
      end
    endcase

    // Reset forces the control outputs quiet without waiting for a clock.
    if (!rst) begin
      {stall_if, stall_id, stall_ex, stall_mem} = 4'b0000;
      clear_id = 1'b0;
      clear_ex = 1'b0;
      pc_we    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      timeout_err <= timeout_err | set_timeout;
    end
  end

endmodule
